// File: rtl/gpio_hex_display.sv
// gpio_hex_display: drives HEX7..HEX0 from the CPU gpio_out value in decimal (double dabble) or hex.
// Optional macro GPIO_HEX_LEADING_ZERO_BLANK_EN blanks leading zeros of decimal results.
module gpio_hex_display #(
    parameter int NUM_BITS   = 32,
    parameter int BCD_DIGITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] value,
    input  logic                hex_mode,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic [6:0]          hex4,
    output logic [6:0]          hex5,
    output logic [6:0]          hex6,
    output logic [6:0]          hex7,
    output logic                busy,
    output logic                overflow
);
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t                  state, state_nx;
    logic [NUM_BITS-1:0]     snap_value, shift;
    logic                    snap_mode, first, start, conv_done, ovf_nx;
    logic [4*BCD_DIGITS-1:0] bcd, bcd_adj;
    logic [CW-1:0]           count;
    logic [31:0]             hex_src;
    logic [3:0]              nib;
    logic [6:0]              disp [8];
    logic [6:0]              nxt  [8];
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
    logic                    lead;
`endif

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    assign start     = first || value != snap_value || hex_mode != snap_mode;
    assign conv_done = count == CW'(NUM_BITS - 1);
    assign hex_src   = 32'(snap_value);
    assign ovf_nx    = !snap_mode && bcd[4*BCD_DIGITS-1:32] != '0;

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // Next-state: capture in IDLE, shift through CONV, one UPDATE edge to publish
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = hex_mode ? UPDATE : CONV;
            CONV:    if (conv_done) state_nx = UPDATE;
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that would overflow after the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd[4*i+:4] >= 4'd5) bcd_adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
    end

    // Segment codes the display will take on the UPDATE edge
    always_comb begin
        nib = '0;
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
`endif
        for (int i = 7; i >= 0; i--) begin
            nib    = snap_mode ? hex_src[4*i+:4] : bcd[4*i+:4];
            nxt[i] = ovf_nx ? DASH : seg(nib);
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
            lead = lead && nib == 4'd0;
            if (!snap_mode && !ovf_nx && lead && i != 0) nxt[i] = BLANK;
`endif
        end
    end

    // Snapshot, converter datapath and glitch-free display registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            snap_value <= '0;
            snap_mode  <= 1'b0;
            first      <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            bcd        <= '0;
            shift      <= '0;
            count      <= '0;
            for (int i = 0; i < 8; i++) disp[i] <= BLANK;
        end else begin
            if (state == IDLE && start) begin
                snap_value <= value;
                snap_mode  <= hex_mode;
                first      <= 1'b0;
                busy       <= 1'b1;
                bcd        <= '0;
                shift      <= value;
                count      <= '0;
            end
            if (state == CONV) begin
                {bcd, shift} <= {bcd_adj, shift} << 1;
                count        <= count + 1'b1;
            end
            if (state == UPDATE) begin
                for (int i = 0; i < 8; i++) disp[i] <= nxt[i];
                busy     <= 1'b0;
                overflow <= ovf_nx;
            end
        end

    assign hex0 = disp[0];
    assign hex1 = disp[1];
    assign hex2 = disp[2];
    assign hex3 = disp[3];
    assign hex4 = disp[4];
    assign hex5 = disp[5];
    assign hex6 = disp[6];
    assign hex7 = disp[7];
endmodule

// File: tb/tb_gpio_hex_display.sv
// tb_gpio_hex_display: randomized self-checking bench for gpio_hex_display against an arithmetic display model.
module tb_gpio_hex_display;
    localparam logic [6:0] SEGT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = '0;
    logic        hex_mode = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy, overflow;
    logic [55:0] disp_obs;

    int          checks = 0;
    int          pass_cnt = 0;
    logic [55:0] prev = ALL_BLANK;
    logic [31:0] last_v = '0;
    logic        last_m = 1'b0;

    gpio_hex_display dut (
        .clk(clk), .rst(rst), .value(value), .hex_mode(hex_mode),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign disp_obs = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    function automatic logic model_ovf(input logic [31:0] v, input logic m);
        return !m && v > 32'd99999999;
    endfunction

    function automatic logic [55:0] model_disp(input logic [31:0] v, input logic m);
        logic [55:0] r;
        longint      q;
        longint      p;
        r = '0;
        if (m) begin
            for (int i = 0; i < 8; i++) r[7*i+:7] = SEGT[v[4*i+:4]];
        end else if (model_ovf(v, m)) begin
            r = {8{7'h3F}};
        end else begin
            q = longint'(v);
            p = 1;
            for (int i = 0; i < 8; i++) begin
                r[7*i+:7] = SEGT[4'(q % 10)];
`ifdef GPIO_HEX_LEADING_ZERO_BLANK_EN
                if (i != 0 && longint'(v) < p) r[7*i+:7] = 7'h7F;
`endif
                q = q / 10;
                p = p * 10;
            end
        end
        return r;
    endfunction

    task automatic do_conv(input logic [31:0] v_in, input logic m, input string name);
        logic [31:0] v;
        logic [55:0] exp_d;
        int          lat;
        v = ({v_in, m} == {last_v, last_m}) ? v_in + 32'd1 : v_in;
        value = v;
        hex_mode = m;
        lat = m ? 2 : 34;
        exp_d = model_disp(v, m);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_start: got %b expected 1", name, busy);
        else pass_cnt++;
        repeat (lat - 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || disp_obs !== prev)
            $display("FAIL %s stale: busy %b disp %h expected busy 1 disp %h", name, busy, disp_obs, prev);
        else pass_cnt++;
        @(negedge clk);
        checks++;
        if (disp_obs !== exp_d || busy !== 1'b0 || overflow !== model_ovf(v, m))
            $display("FAIL %s result v=%0d m=%b: disp %h busy %b ovf %b expected disp %h busy 0 ovf %b",
                     name, v, m, disp_obs, busy, overflow, exp_d, model_ovf(v, m));
        else pass_cnt++;
        prev = exp_d;
        last_v = v;
        last_m = m;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        value = '0;
        hex_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (disp_obs !== ALL_BLANK || busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset: disp %h busy %b ovf %b expected %h 0 0", disp_obs, busy, overflow, ALL_BLANK);
        else pass_cnt++;
        rst = 1'b1;
        last_v = 32'hFFFF_FFFF;
        last_m = 1'b1;
        do_conv(32'd0, 1'b0, "first_zero");
    endtask

    task automatic test_decimal();
        do_conv(32'd12345678, 1'b0, "dec_12345678");
        for (int i = 0; i < 4; i++) do_conv($urandom_range(0, 99999999), 1'b0, "dec_rand");
        for (int i = 0; i < 3; i++) do_conv($urandom_range(0, 9999), 1'b0, "dec_small");
    endtask

    task automatic test_overflow();
        do_conv(32'd100000000, 1'b0, "ovf_100000000");
        do_conv(32'd99999999, 1'b0, "max_99999999");
        do_conv(32'hFFFF_FFFF, 1'b0, "ovf_max");
        do_conv($urandom_range(100000000, 32'hFFFF_FFFE), 1'b0, "ovf_rand");
    endtask

    task automatic test_hex();
        do_conv(32'hDEADBEEF, 1'b1, "hex_deadbeef");
        for (int i = 0; i < 4; i++) do_conv($urandom, 1'b1, "hex_rand");
        do_conv(last_v, 1'b0, "mode_to_dec");
    endtask

    task automatic test_change_while_busy();
        logic [55:0] exp5, exp42;
        exp5 = model_disp(32'd5, 1'b0);
        exp42 = model_disp(32'd42, 1'b0);
        value = 32'd5;
        hex_mode = 1'b0;
        repeat (10) @(negedge clk);
        value = 32'd42;
        repeat (24) @(negedge clk);
        checks++;
        if (disp_obs !== exp5 || busy !== 1'b0)
            $display("FAIL busy_change_first: disp %h busy %b expected %h 0", disp_obs, busy, exp5);
        else pass_cnt++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_change_restart: got busy %b expected 1", busy);
        else pass_cnt++;
        repeat (32) @(negedge clk);
        checks++;
        if (disp_obs !== exp5) $display("FAIL busy_change_stale: got %h expected %h", disp_obs, exp5);
        else pass_cnt++;
        @(negedge clk);
        checks++;
        if (disp_obs !== exp42 || busy !== 1'b0)
            $display("FAIL busy_change_second: disp %h busy %b expected %h 0", disp_obs, busy, exp42);
        else pass_cnt++;
        prev = exp42;
        last_v = 32'd42;
        last_m = 1'b0;
    endtask

    task automatic test_constant();
        int busy_seen;
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || disp_obs !== prev)
            $display("FAIL constant: busy cycles %0d disp %h expected 0 and %h", busy_seen, disp_obs, prev);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        v = $urandom_range(1000, 99999999);
        if (v == last_v) v = v + 32'd1;
        value = v;
        hex_mode = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (disp_obs !== ALL_BLANK || busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_mid: disp %h busy %b ovf %b expected %h 0 0", disp_obs, busy, overflow, ALL_BLANK);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        prev = ALL_BLANK;
        last_v = ~v;
        do_conv(v, 1'b0, "after_reset_mid");
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_overflow();
        test_hex();
        test_change_while_busy();
        test_constant();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end
endmodule
